gray_encoder_stream: RTL and testbench
======================================

Name: gray_encoder_stream

Overview:
Binary-to-Gray encoder with a registered valid/ready output stage. It is the transmit-side counterpart of the registered Gray-to-binary decoder. It runs in one of two modes:
- PASS: encodes an incoming binary stream.
- COUNT: acts as a free-running up/down Gray sequence generator.
Output feeds the decoder or any Gray-coded consumer, e.g. a CDC pointer path.

Parameters:
W, 4, data width in bits; legal range 2..16.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
mode  in  1  0 = PASS, 1 = COUNT; sampled only on a load cycle.
in_valid  in  1  PASS-mode input sample valid.
in_ready  out  1  block can accept in_bin this cycle.
in_bin  in  W  binary input sample.
cnt_en  in  1  COUNT mode: emit the next sequence value.
cnt_dn  in  1  COUNT mode: 0 = count up, 1 = count down.
out_valid  out  1  out_gray/out_bin hold a valid word.
out_ready  in  1  consumer accepts the word this cycle.
out_gray  out  W  Gray-coded word.
out_bin  out  W  binary source of out_gray, for checking.
out_single  out  1  out_gray differs from the previously loaded Gray word in exactly one bit.
wrap  out  1  COUNT mode: the counter stepped across its end while producing this word.

Behaviour:
- Clock/reset: reset rst, asynchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values: out_valid=0, out_gray=0, out_bin=0, out_single=0, wrap=0, internal count=0, last_gray=0. Reset asserted mid-transfer discards the held word; no word is emitted on reset release.
- Load condition: load_ok = !out_valid || out_ready (single output register, full throughput).
- in_ready = load_ok && (mode==PASS). In COUNT mode, in_ready=0 and in_bin is ignored.
- PASS load, when in_valid && in_ready:
  - out_bin <= in_bin
  - out_gray <= in_bin ^ (in_bin >> 1)
  - out_valid <= 1
  - Latency: 1 cycle from the accepting edge to out_valid.
- COUNT load, when cnt_en && load_ok && mode==COUNT:
  - out_bin <= count; out_gray <= Gray(count); out_valid <= 1.
  - count <= count+1 (cnt_dn=0) or count-1 (cnt_dn=1), modulo 2^W.
  - The first word after reset is 0.
  - wrap <= 1 if this step goes 2^W-1 -> 0 (up) or 0 -> 2^W-1 (down); otherwise wrap <= 0.
- No load while load_ok: if out_ready && out_valid, then out_valid <= 0. out_gray/out_bin/out_single/wrap keep their values and are don't-care while out_valid=0.
- Stall: while out_valid && !out_ready, every output is held stable. No input is accepted and count does not advance.
- out_single:
  - On each load: out_single <= (popcount(new_gray ^ last_gray) == 1); then last_gray <= new_gray.
  - A load equal to last_gray gives out_single=0.
  - The first load after reset compares against 0.
- Mode switching:
  - mode only matters on a load cycle.
  - count is retained while in PASS mode.
  - last_gray spans both modes.
  - A mode change while a word is held does not alter that word.
- Simultaneous events: on the same edge, a transfer out plus a new load yields a back-to-back new word with out_valid staying 1. cnt_dn may change on any load cycle; direction applies to that step.
- Width rules: all arithmetic is unsigned W-bit with natural wrap. Shifts are logical.

Decomposition:
- Package gray_pkg holds:
  - mode_e enum (PASS, COUNT).
  - Function bin2gray(W).
  - Function gray2bin(W), shared with the decoder and the bench.
  - Function is_onehot(W) for the out_single check.
- No sub-module is needed: encoder, counter and output register fit in one module.
- Optional: factor the output register as a parameterised reg_slice if the team reuses it elsewhere.

Test Plan:
- Count up, W=4, mode=1, cnt_en=1, out_ready=1 from reset: out_gray sequence 0000,0001,0011,0010,0110,...,1000; 17th word is 0000 with wrap=1 on the 16th step word (bin 1111); out_single=1 on every word except the first (0 vs 0 -> 0).
- Count down from reset, W=4: first word bin 0000/gray 0000 with wrap=1; next bin 1111/gray 1000, then 1110/1001; out_single=1 from the second word onward.
- PASS, W=4: in_bin=1011 accepted at edge N -> out_valid=1, out_gray=1110, out_bin=1011 after edge N. Next in_bin=0101 -> out_gray=0111, out_single=0 (1110^0111 has 2 ones).
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs frozen, no count advance; out_ready=1 -> exactly one transfer per cycle afterwards, no word lost or duplicated (scoreboard via gray2bin).
- Reset mid-stall: out_valid=1, out_ready=0, assert rst asynchronously between edges -> out_valid, out_gray and wrap go 0 immediately. After release, COUNT restarts at 0000.
- Mode switch: in COUNT, emit 0,1,2; switch to PASS and send 1100 -> out_gray 1010; switch back to COUNT -> next word bin 0011/gray 0010 (count retained).

Source files
------------

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code types and helper functions
package gray_pkg;

    localparam int MAXW = 16;

    typedef logic [MAXW-1:0] word_t;

    typedef enum logic {
        PASS  = 1'b0,
        COUNT = 1'b1
    } mode_e;

    // Narrower words are zero-extended into word_t, which leaves the result unchanged
    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b = '0;
        for (int i = 0; i < MAXW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic logic is_onehot(input word_t v);
        return (v != '0) && ((v & (v - word_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_encoder_stream.sv
// rtl/gray_encoder_stream.sv - binary-to-Gray encoder / Gray counter with registered valid/ready output
module gray_encoder_stream
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_bin,
    input  logic         cnt_en,
    input  logic         cnt_dn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gray,
    output logic [W-1:0] out_bin,
    output logic         out_single,
    output logic         wrap
);

    mode_e        cur_mode;
    logic         load_ok;
    logic         pass_load;
    logic         cnt_load;
    logic         load;
    logic [W-1:0] count;
    logic [W-1:0] next_count;
    logic [W-1:0] last_gray;
    logic [W-1:0] new_bin;
    logic [W-1:0] new_gray;
    logic         new_wrap;
    logic         new_single;

    assign cur_mode  = mode_e'(mode);
    // A single output register gives full throughput: reload whenever the word leaves or is absent
    assign load_ok   = !out_valid || out_ready;
    assign in_ready  = load_ok && (cur_mode == PASS);
    assign pass_load = in_valid && in_ready;
    assign cnt_load  = cnt_en && load_ok && (cur_mode == COUNT);
    assign load      = pass_load || cnt_load;

    // Select the word to load and compute the counter step and its wrap flag
    always_comb begin
        new_bin    = count;
        next_count = count;
        new_wrap   = 1'b0;
        if (cnt_load) begin
            if (cnt_dn) begin
                next_count = count - W'(1);
                new_wrap   = (count == '0);
            end else begin
                next_count = count + W'(1);
                new_wrap   = (count == '1);
            end
        end
        if (pass_load) begin
            new_bin = in_bin;
        end
        new_gray   = W'(bin2gray(MAXW'(new_bin)));
        new_single = is_onehot(MAXW'(new_gray ^ last_gray));
    end

    // Output register, counter and last-loaded Gray word; hold everything during a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_gray   <= '0;
            out_bin    <= '0;
            out_single <= 1'b0;
            wrap       <= 1'b0;
            count      <= '0;
            last_gray  <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_gray   <= new_gray;
            out_bin    <= new_bin;
            out_single <= new_single;
            wrap       <= new_wrap;
            last_gray  <= new_gray;
            count      <= next_count;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_encoder_stream.sv
// tb/tb_gray_encoder_stream.sv - directed self-checking bench for gray_encoder_stream
module tb_gray_encoder_stream;
    import gray_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_bin;
    logic         cnt_en;
    logic         cnt_dn;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gray;
    logic [W-1:0] out_bin;
    logic         out_single;
    logic         wrap;

    int n_checks = 0;
    int n_fail   = 0;

    gray_encoder_stream #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bin     (in_bin),
        .cnt_en     (cnt_en),
        .cnt_dn     (cnt_dn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gray   (out_gray),
        .out_bin    (out_bin),
        .out_single (out_single),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [3:0] b, input logic [3:0] g,
                              input logic s, input logic w);
        check({tag, " valid"},  32'(out_valid),  32'd1);
        check({tag, " bin"},    32'(out_bin),    32'(b));
        check({tag, " gray"},   32'(out_gray),   32'(g));
        check({tag, " single"}, 32'(out_single), 32'(s));
        check({tag, " wrap"},   32'(wrap),       32'(w));
    endtask

    logic [3:0] gtab [16];

    initial begin
        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_bin = '0;
        cnt_en = 1'b0; cnt_dn = 1'b0; out_ready = 1'b0;
        #2;
        check("rst out_valid",  32'(out_valid),  32'd0);
        check("rst out_gray",   32'(out_gray),   32'd0);
        check("rst out_bin",    32'(out_bin),    32'd0);
        check("rst out_single", 32'(out_single), 32'd0);
        check("rst wrap",       32'(wrap),       32'd0);
        check("rst in_ready",   32'(in_ready),   32'd1);
        tick();
        rst = 1'b0;

        // Count up through a full cycle and one word past the wrap
        mode = 1'b1; cnt_en = 1'b1; cnt_dn = 1'b0; out_ready = 1'b1;
        #1;
        check("count in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 17; i++) begin
            tick();
            check_word($sformatf("up%0d", i), 4'(i), gtab[i % 16], (i != 0), (i == 15));
        end
        cnt_en = 1'b0;
        tick();
        check("up drain valid", 32'(out_valid), 32'd0);

        // Count down from reset
        rst = 1'b1;
        #1;
        check("rst2 out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        cnt_en = 1'b1; cnt_dn = 1'b1;
        tick(); check_word("dn0", 4'h0, 4'h0, 1'b0, 1'b1);
        tick(); check_word("dn1", 4'hF, 4'h8, 1'b1, 1'b0);
        tick(); check_word("dn2", 4'hE, 4'h9, 1'b1, 1'b0);
        cnt_en = 1'b0; cnt_dn = 1'b0;
        tick();

        // PASS mode from a clean reset
        rst = 1'b1; #1; rst = 1'b0;
        mode = 1'b0; in_valid = 1'b1; in_bin = 4'b1011;
        #1;
        check("pass in_ready", 32'(in_ready), 32'd1);
        tick(); check_word("pass0", 4'b1011, 4'b1110, 1'b0, 1'b0);
        in_bin = 4'b0101;
        tick(); check_word("pass1", 4'b0101, 4'b0111, 1'b0, 1'b0);
        in_bin = 4'b0100;
        tick(); check_word("pass2", 4'b0100, 4'b0110, 1'b1, 1'b0);

        // Backpressure: word 0100 held for five edges
        out_ready = 1'b0; in_bin = 4'b0111;
        #1;
        check("stall in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d gray", i),  32'(out_gray),  32'(4'b0110));
        end
        out_ready = 1'b1;
        tick();
        check("bp0 valid", 32'(out_valid), 32'd1);
        check("bp0 scoreboard", 32'(gray2bin(MAXW'(out_gray))), 32'(4'b0111));
        in_bin = 4'b1000;
        tick();
        check("bp1 scoreboard", 32'(gray2bin(MAXW'(out_gray))), 32'(4'b1000));
        check("bp1 gray", 32'(out_gray), 32'(4'b1100));

        // Reset asserted between edges while a word is stalled
        in_valid = 1'b0; out_ready = 1'b0; mode = 1'b1; cnt_en = 1'b1;
        tick();
        check("pre-rst valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst valid", 32'(out_valid), 32'd0);
        check("midrst gray",  32'(out_gray),  32'd0);
        check("midrst wrap",  32'(wrap),      32'd0);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick(); check_word("ms0", 4'h0, 4'h0, 1'b0, 1'b0);
        tick(); check_word("ms1", 4'h1, 4'h1, 1'b1, 1'b0);
        tick(); check_word("ms2", 4'h2, 4'h3, 1'b1, 1'b0);

        // Stall in COUNT mode must not advance the counter
        out_ready = 1'b0;
        tick(); tick();
        check("cstall bin", 32'(out_bin), 32'd2);

        // Switch to PASS, then back to COUNT with the count retained
        mode = 1'b0; cnt_en = 1'b0; in_valid = 1'b1; in_bin = 4'b1100; out_ready = 1'b1;
        tick(); check_word("ms_pass", 4'b1100, 4'b1010, 1'b0, 1'b0);
        mode = 1'b1; cnt_en = 1'b1; in_valid = 1'b0;
        tick(); check_word("ms_back", 4'b0011, 4'b0010, 1'b1, 1'b0);
        cnt_en = 1'b0;
        tick();
        check("final drain valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
